// File: rtl/k7_pkg.sv
// Shared definitions for the K7 cassette transmitter: FSM states, tape formats,
// slow-format cycle counts and frame/phase helpers.
package k7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } k7_state_t;

    typedef enum logic {
        FAST = 1'b0,
        SLOW = 1'b1
    } k7_fmt_t;

    localparam int SLOW_ONE_CYCLES  = 8;
    localparam int SLOW_ZERO_CYCLES = 4;

    // Bit idx of the frame: start '0', data LSB first, odd parity, then stop '1's.
    function automatic logic frame_bit(logic [7:0] d, int idx);
        if (idx == 0)
            return 1'b0;
        if (idx <= 8)
            return d[3'(idx - 1)];
        if (idx == 9)
            return ~^d;
        return 1'b1;
    endfunction

    function automatic logic [9:0] high_len(logic b, k7_fmt_t f, int half);
        return (f == SLOW && !b) ? 10'(2 * half) : 10'(half);
    endfunction

    function automatic logic [9:0] low_len(logic b, int half);
        return b ? 10'(half) : 10'(2 * half);
    endfunction

    function automatic logic [2:0] last_cycle(logic b);
        return b ? 3'(SLOW_ONE_CYCLES - 1) : 3'(SLOW_ZERO_CYCLES - 1);
    endfunction

endpackage

// File: rtl/k7_phase_timer.sv
// Loadable 10-bit tick down-counter; done pulses on the tick that takes it from 1 to 0.
module k7_phase_timer (
    input  logic       CLK_IN,
    input  logic       RESET,
    input  logic       ena,
    input  logic       load,
    input  logic [9:0] load_val,
    output logic       done
);

    logic [9:0] count;

    assign done = ena && (count == 10'd1);

    always_ff @(posedge CLK_IN) begin
        if (RESET)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (ena && count != 10'd0)
            count <= count - 10'd1;
    end

endmodule

// File: rtl/k7_tape_tx.sv
// Byte-to-cassette modulator: frames a byte and emits it as HIGH/LOW pulse phases
// whose lengths encode each bit in the fast or slow format.
module k7_tape_tx
    import k7_pkg::*;
#(
    parameter int HALF_US   = 208,
    parameter int STOP_BITS = 4
) (
    input  logic       CLK_IN,
    input  logic       RESET,
    input  logic       ENA_1MHZ,
    input  logic       play,
    input  logic       slow,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tape_out,
    output logic       busy
);

    localparam int LAST_IDX = 10 + STOP_BITS - 1;
    localparam int IDX_W    = $clog2(LAST_IDX + 1);

    k7_state_t        state;
    k7_fmt_t          fmt_q;
    logic [7:0]       data_q;
    logic [IDX_W-1:0] bit_idx;
    logic [2:0]       cyc_cnt;
    logic             load;
    logic [9:0]       load_val;
    logic             done;
    logic             xfer;
    logic             cur_bit;
    logic             next_bit;
    logic             last_cyc;
    logic             last_bit;

    assign data_ready = play && (state == IDLE) && !RESET;
    assign xfer       = data_valid && data_ready;
    assign busy       = (state != IDLE);
    assign cur_bit    = frame_bit(data_q, int'(bit_idx));
    assign next_bit   = frame_bit(data_q, int'(bit_idx) + 1);
    assign last_cyc   = (fmt_q == FAST) || (cyc_cnt == last_cycle(cur_bit));
    assign last_bit   = (bit_idx == IDX_W'(LAST_IDX));

    k7_phase_timer u_timer (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .ena      (ENA_1MHZ),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // Timer reload runs in step with the FSM: the next phase length is loaded on
    // the same edge that the FSM enters that phase. The start bit is always '0'.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (state == IDLE && xfer) begin
            load     = 1'b1;
            load_val = high_len(1'b0, k7_fmt_t'(slow), HALF_US);
        end else if (done && state == HIGH) begin
            load     = 1'b1;
            load_val = low_len(cur_bit, HALF_US);
        end else if (done && state == LOW) begin
            if (!last_cyc) begin
                load     = 1'b1;
                load_val = high_len(cur_bit, fmt_q, HALF_US);
            end else if (!last_bit) begin
                load     = 1'b1;
                load_val = high_len(next_bit, fmt_q, HALF_US);
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state    <= IDLE;
            tape_out <= 1'b0;
            fmt_q    <= FAST;
            data_q   <= '0;
            bit_idx  <= '0;
            cyc_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        data_q   <= data_in;
                        fmt_q    <= k7_fmt_t'(slow);
                        bit_idx  <= '0;
                        cyc_cnt  <= '0;
                        state    <= HIGH;
                        tape_out <= 1'b1;
                    end
                end
                HIGH: begin
                    if (done) begin
                        state    <= LOW;
                        tape_out <= 1'b0;
                    end
                end
                LOW: begin
                    if (done) begin
                        if (!last_cyc) begin
                            cyc_cnt  <= cyc_cnt + 3'd1;
                            state    <= HIGH;
                            tape_out <= 1'b1;
                        end else if (!last_bit) begin
                            bit_idx  <= bit_idx + 1'b1;
                            cyc_cnt  <= '0;
                            state    <= HIGH;
                            tape_out <= 1'b1;
                        end else begin
                            bit_idx  <= '0;
                            cyc_cnt  <= '0;
                            state    <= IDLE;
                            tape_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tape_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k7_tape_tx.sv
// Self-checking bench for k7_tape_tx: one instance at the default half-period for the
// long timing cases and a short-period instance for the protocol and randomized cases.
module tb_k7_tape_tx;

    localparam int LONG_HALF  = 208;
    localparam int QUICK_HALF = 6;
    localparam int STOPS      = 4;

    logic       CLK_IN = 1'b0;
    logic       RESET = 1'b1;
    logic       ENA_1MHZ = 1'b1;
    logic       play = 1'b0;
    logic       slow = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic rdyL, tapeL, busyL;
    logic rdyQ, tapeQ, busyQ;

    bit   useQuick = 1'b0;
    bit   randomEna = 1'b0;
    logic sTape, sBusy, sRdy;

    int checks = 0;
    int errors = 0;
    int runs[$];
    int expRuns[$];
    int totalTicks;

    k7_tape_tx dutLong (
        .CLK_IN     (CLK_IN),
        .RESET      (RESET),
        .ENA_1MHZ   (ENA_1MHZ),
        .play       (play),
        .slow       (slow),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (rdyL),
        .tape_out   (tapeL),
        .busy       (busyL)
    );

    k7_tape_tx #(.HALF_US(QUICK_HALF), .STOP_BITS(STOPS)) dutQuick (
        .CLK_IN     (CLK_IN),
        .RESET      (RESET),
        .ENA_1MHZ   (ENA_1MHZ),
        .play       (play),
        .slow       (slow),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (rdyQ),
        .tape_out   (tapeQ),
        .busy       (busyQ)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Sample the selected instance on the falling edge, then pick ENA for the next rising edge.
    task automatic nextCycle();
        @(negedge CLK_IN);
        sTape = useQuick ? tapeQ : tapeL;
        sBusy = useQuick ? busyQ : busyL;
        sRdy  = useQuick ? rdyQ  : rdyL;
        ENA_1MHZ = randomEna ? ($urandom_range(0, 7) != 0) : 1'b1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: frame bits from the byte, then each bit expands to its phase lengths in ticks.
    function automatic void buildExpected(input logic [7:0] d, input bit s, input int h);
        bit frame[$];
        expRuns.delete();
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(bit'(d[i]));
        frame.push_back(($countones(d) % 2) == 0);
        for (int i = 0; i < STOPS; i++) frame.push_back(1'b1);
        foreach (frame[i]) begin
            if (!s) begin
                expRuns.push_back(h);
                expRuns.push_back(frame[i] ? h : 2 * h);
            end else if (frame[i]) begin
                repeat (8) begin expRuns.push_back(h); expRuns.push_back(h); end
            end else begin
                repeat (4) begin expRuns.push_back(2 * h); expRuns.push_back(2 * h); end
            end
        end
    endfunction

    task automatic applyStimulus(input string tag, input logic [7:0] d, input bit s, input bit holdValid);
        int g = 0;
        data_in    = d;
        slow       = s;
        data_valid = 1'b1;
        while (!sRdy && g < 1000) begin
            nextCycle();
            g++;
        end
        checkOutput({tag, " ready"}, int'(sRdy), 1);
        nextCycle();
        if (!holdValid) data_valid = 1'b0;
        checkOutput({tag, " start tape"}, int'(sTape), 1);
        checkOutput({tag, " start busy"}, int'(sBusy), 1);
    endtask

    task automatic captureFrame(input int dropAt, input int stopAt);
        logic level = 1'b1;
        int   cur = 0;
        int   g = 0;
        runs.delete();
        totalTicks = 0;
        while (sBusy && g < 100000) begin
            if (sTape !== level) begin
                runs.push_back(cur);
                cur   = 0;
                level = sTape;
                if (runs.size() == stopAt) return;
            end
            if (dropAt >= 0 && runs.size() == dropAt) play = 1'b0;
            if (ENA_1MHZ) begin
                cur++;
                totalTicks++;
            end
            nextCycle();
            g++;
        end
        runs.push_back(cur);
        checkOutput("frame within budget", int'(g < 100000), 1);
        checkOutput("idle tape after frame", int'(sTape), 0);
    endtask

    task automatic compareRuns(input string tag);
        int sum = 0;
        foreach (expRuns[i]) sum += expRuns[i];
        checkOutput({tag, " phase count"}, runs.size(), expRuns.size());
        for (int i = 0; i < runs.size() && i < expRuns.size(); i++) begin
            checkOutput($sformatf("%s phase %0d", tag, i), runs[i], expRuns[i]);
            if (runs[i] != expRuns[i]) break;
        end
        checkOutput({tag, " total ticks"}, totalTicks, sum);
    endtask

    task automatic doReset();
        RESET      = 1'b1;
        data_valid = 1'b0;
        play       = 1'b0;
        repeat (3) nextCycle();
        RESET = 1'b0;
        nextCycle();
    endtask

    initial begin
        int idle;
        int sawBusy;
        int sawRdy;
        logic [7:0] r;
        bit rs;

        $display("[TB] start");
        play = 1'b1;
        repeat (3) nextCycle();
        checkOutput("reset tape", int'(sTape), 0);
        checkOutput("reset busy", int'(sBusy), 0);
        checkOutput("reset ready", int'(sRdy), 0);
        RESET = 1'b0;
        nextCycle();
        checkOutput("ready after reset", int'(sRdy), 1);

        buildExpected(8'h00, 1'b0, LONG_HALF);
        applyStimulus("fast00", 8'h00, 1'b0, 1'b0);
        captureFrame(-1, -1);
        compareRuns("fast00");
        checkOutput("fast00 ticks", totalTicks, 7696);

        buildExpected(8'hFF, 1'b0, LONG_HALF);
        applyStimulus("fastFF", 8'hFF, 1'b0, 1'b0);
        captureFrame(-1, -1);
        compareRuns("fastFF");
        checkOutput("fastFF ticks", totalTicks, 6032);
        checkOutput("fastFF start low", runs[1], 416);

        buildExpected(8'h00, 1'b1, LONG_HALF);
        applyStimulus("slow00", 8'h00, 1'b1, 1'b0);
        captureFrame(-1, -1);
        compareRuns("slow00");
        checkOutput("slow00 ticks", totalTicks, 46592);

        useQuick  = 1'b1;
        randomEna = 1'b1;
        doReset();
        data_in    = 8'hA5;
        data_valid = 1'b1;
        sawBusy = 0;
        sawRdy  = 0;
        repeat (20) begin
            nextCycle();
            sawBusy += int'(sBusy);
            sawRdy  += int'(sRdy);
        end
        checkOutput("no play busy", sawBusy, 0);
        checkOutput("no play ready", sawRdy, 0);
        data_valid = 1'b0;
        play = 1'b1;
        nextCycle();
        buildExpected(8'h96, 1'b1, QUICK_HALF);
        applyStimulus("after noplay", 8'h96, 1'b1, 1'b0);
        captureFrame(-1, -1);
        compareRuns("after noplay");

        buildExpected(8'h55, 1'b0, QUICK_HALF);
        applyStimulus("b2b55", 8'h55, 1'b0, 1'b1);
        data_in = 8'hAA;
        captureFrame(-1, -1);
        compareRuns("b2b55");
        checkOutput("b2b55 parity low", runs[19], QUICK_HALF);
        idle = 0;
        while (!sBusy && idle < 50) begin
            idle++;
            nextCycle();
        end
        data_valid = 1'b0;
        checkOutput("b2b idle cycles", idle, 1);
        buildExpected(8'hAA, 1'b0, QUICK_HALF);
        captureFrame(-1, -1);
        compareRuns("b2bAA");
        checkOutput("b2bAA parity low", runs[19], QUICK_HALF);

        buildExpected(8'h3C, 1'b0, QUICK_HALF);
        applyStimulus("drop3C", 8'h3C, 1'b0, 1'b1);
        captureFrame(9, -1);
        compareRuns("drop3C");
        sawBusy = 0;
        sawRdy  = 0;
        repeat (20) begin
            nextCycle();
            sawBusy += int'(sBusy);
            sawRdy  += int'(sRdy);
        end
        checkOutput("drop held valid busy", sawBusy, 0);
        checkOutput("drop ready", sawRdy, 0);
        data_valid = 1'b0;
        play = 1'b1;
        nextCycle();

        applyStimulus("resetFF", 8'hFF, 1'b0, 1'b0);
        captureFrame(-1, 18);
        checkOutput("reached parity", runs.size(), 18);
        RESET = 1'b1;
        nextCycle();
        checkOutput("mid reset tape", int'(sTape), 0);
        checkOutput("mid reset busy", int'(sBusy), 0);
        checkOutput("mid reset ready", int'(sRdy), 0);
        RESET = 1'b0;
        nextCycle();
        checkOutput("post reset ready", int'(sRdy), 1);
        r = 8'($urandom_range(0, 255));
        buildExpected(r, 1'b0, QUICK_HALF);
        applyStimulus("post reset", r, 1'b0, 1'b0);
        captureFrame(-1, -1);
        compareRuns("post reset");

        for (int k = 0; k < 4; k++) begin
            r  = 8'($urandom_range(0, 255));
            rs = bit'($urandom_range(0, 1));
            buildExpected(r, rs, QUICK_HALF);
            applyStimulus($sformatf("rand%0d", k), r, rs, 1'b0);
            captureFrame(-1, -1);
            compareRuns($sformatf("rand%0d byte %02h slow %0d", k, r, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
